// File: rtl/dct_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dct_frame_scheduler_if
// Purpose  : Input stream, core and output stream bundle for the DCT scheduler.
// Revision : 1.0
// ============================================================================
interface dct_frame_scheduler_if #(
    parameter int M         = 23,
    parameter int E         = 8,
    parameter int DCT_POINT = 16
);
    localparam int c_W = M + E + 1;
    localparam int c_B = c_W * DCT_POINT;

    logic           in_valid;
    logic           in_ready;
    logic [c_B-1:0] in_data;
    logic [c_B-1:0] core_inp;
    logic           core_en;
    logic           core_F;
    logic [c_B-1:0] core_outp;
    logic           out_valid;
    logic           out_ready;
    logic [c_B-1:0] out_data;

    // Environment side: produces blocks, models the core, consumes results.
    modport master (
        output in_valid, in_data, core_F, core_outp, out_ready,
        input  in_ready, core_inp, core_en, out_valid, out_data
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_data, core_F, core_outp, out_ready,
        output in_ready, core_inp, core_en, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/dct_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dct_frame_scheduler
// Purpose  : 2-deep block FIFO feeding a CORDIC DCT core with timeout guard.
// Revision : 1.0
// ============================================================================
module dct_frame_scheduler #(
    parameter int M         = 23,
    parameter int E         = 8,
    parameter int DCT_POINT = 16,
    parameter int TIMEOUT   = 40
) (
    input  logic                 clk,
    input  logic                 clr,
    dct_frame_scheduler_if.slave bus,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [15:0]          blk_count
);
    localparam int c_W  = M + E + 1;
    localparam int c_B  = c_W * DCT_POINT;
    localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CYC_LAST = c_CW'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [c_B-1:0]  r_fifo [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cyc_cnt;
    logic [c_B-1:0]  r_core_inp;
    logic            r_core_en;
    logic            r_out_valid;
    logic [c_B-1:0]  r_out_data;
    logic            r_busy;
    logic            r_err_timeout;
    logic [15:0]     r_blk_count;

    logic w_full;
    logic w_push;
    logic w_out_free;
    logic w_pop;

    assign w_full     = (r_count == 2'd2);
    assign w_push     = bus.in_valid && !w_full;
    // A pending result being taken this cycle frees the output register for the next launch.
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_pop      = (r_state == c_IDLE) && (r_count != 2'd0) && w_out_free;

    assign bus.in_ready  = !w_full;
    assign bus.core_inp  = r_core_inp;
    assign bus.core_en   = r_core_en;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = r_busy;
    assign err_timeout   = r_err_timeout;
    assign blk_count     = r_blk_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.in_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= c_IDLE;
            r_cyc_cnt     <= '0;
            r_core_inp    <= '0;
            r_core_en     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_blk_count   <= 16'd0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_core_inp <= r_fifo[r_rd_ptr];
                        r_core_en  <= 1'b1;
                        r_cyc_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    if (bus.core_F) begin
                        r_out_data  <= bus.core_outp;
                        r_out_valid <= 1'b1;
                        r_blk_count <= r_blk_count + 16'd1;
                        r_core_en   <= 1'b0;
                        r_state     <= c_GAP;
                    end else if (r_cyc_cnt == c_CYC_LAST) begin
                        // Block is dropped; the output register keeps its previous content.
                        r_err_timeout <= 1'b1;
                        r_core_en     <= 1'b0;
                        r_state       <= c_GAP;
                    end
                end
                c_GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_core_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dct_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_frame_scheduler
// Purpose  : Scoreboard bench for dct_frame_scheduler with a CORDIC core stub.
// Revision : 1.0
// ============================================================================
module tb_dct_frame_scheduler;
    localparam int c_B = (23 + 8 + 1) * 16;

    typedef struct {
        logic [c_B-1:0] data;
        logic [15:0]    blk;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        busy;
    logic        err_timeout;
    logic [15:0] blk_count;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [15:0] exp_blk = 16'd0;

    logic           stub_on  = 1'b1;
    logic           manual_f = 1'b0;
    logic [c_B-1:0] manual_data = '0;
    int             stub_cnt = 0;

    always #5 clk = ~clk;

    dct_frame_scheduler_if bus_if ();

    dct_frame_scheduler dut (
        .clk         (clk),
        .clr         (clr),
        .bus         (bus_if),
        .busy        (busy),
        .err_timeout (err_timeout),
        .blk_count   (blk_count)
    );

    function automatic logic [c_B-1:0] stub_fn(input logic [c_B-1:0] x);
        return x ^ {16{32'h5A3C_96E1}};
    endfunction

    task automatic check(input string name, input logic [c_B-1:0] act, input logic [c_B-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Core stub: pulses core_F on the 31st cycle core_en has been high.
    always @(negedge clk) begin
        if (bus_if.core_en) stub_cnt = stub_cnt + 1;
        else                stub_cnt = 0;
        if (manual_f) begin
            bus_if.core_F    = 1'b1;
            bus_if.core_outp = manual_data;
        end else if (stub_on && bus_if.core_en && stub_cnt == 31) begin
            bus_if.core_F    = 1'b1;
            bus_if.core_outp = stub_fn(bus_if.core_inp);
        end else begin
            bus_if.core_F    = 1'b0;
            bus_if.core_outp = '0;
        end
    end

    // Monitor: every accepted result is checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!clr && bus_if.out_valid && bus_if.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: actual=%0h required=none", bus_if.out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", bus_if.out_data, e.data);
                check("out_blk_count", c_B'(blk_count), c_B'(e.blk));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_blk(input logic [c_B-1:0] d);
        exp_t e;
        exp_blk = exp_blk + 16'd1;
        e.data  = stub_fn(d);
        e.blk   = exp_blk;
        sb.push_back(e);
    endtask

    task automatic push(input logic [c_B-1:0] d);
        logic done;
        done = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        for (int i = 0; i < 300 && !done; i++) begin
            if (bus_if.in_ready) done = 1'b1;
            tick();
        end
        bus_if.in_valid = 1'b0;
        if (!done) check("push_accept", c_B'(0), c_B'(1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            tick();
            n++;
        end
        tick();
        check("drain", c_B'(sb.size()), c_B'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},    c_B'(bus_if.in_ready),  c_B'(1));
        check({tag, "_core_en"},     c_B'(bus_if.core_en),   c_B'(0));
        check({tag, "_core_inp"},    bus_if.core_inp,        c_B'(0));
        check({tag, "_out_valid"},   c_B'(bus_if.out_valid), c_B'(0));
        check({tag, "_out_data"},    bus_if.out_data,        c_B'(0));
        check({tag, "_busy"},        c_B'(busy),             c_B'(0));
        check({tag, "_err_timeout"}, c_B'(err_timeout),      c_B'(0));
        check({tag, "_blk_count"},   c_B'(blk_count),        c_B'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [c_B-1:0] a, b, c, d, f, g, h;
        logic [15:0]    saved;
        int             n;

        a = {16{32'h3F80_0000}};
        b = {16{32'h4000_0001}};
        c = {16{32'hC0A0_1234}};
        d = {16{32'h0000_FFFF}};
        f = {16{32'h7F7F_0F0F}};
        g = {16{32'h1234_5678}};
        h = {16{32'hDEAD_BEEF}};

        clr = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        tick();
        tick();
        clr = 1'b0;
        check_reset_state("reset");

        // Single block: launch latency, run length, GAP cycle.
        bus_if.out_ready = 1'b1;
        expect_blk(a);
        push(a);
        check("launch_not_early", c_B'(bus_if.core_en), c_B'(0));
        tick();
        check("launch_core_en", c_B'(bus_if.core_en), c_B'(1));
        check("launch_core_inp", bus_if.core_inp, a);
        check("launch_busy", c_B'(busy), c_B'(1));
        n = 0;
        while (bus_if.core_en && n < 100) begin
            n++;
            tick();
        end
        check("run_len", c_B'(n), c_B'(31));
        check("gap_busy", c_B'(busy), c_B'(1));
        check("done_out_valid", c_B'(bus_if.out_valid), c_B'(1));
        check("done_blk_count", c_B'(blk_count), c_B'(1));
        tick();
        check("idle_busy", c_B'(busy), c_B'(0));
        check("idle_core_en", c_B'(bus_if.core_en), c_B'(0));
        check("consumed_out_valid", c_B'(bus_if.out_valid), c_B'(0));

        // Back-pressure: results held, FIFO fills, next launch waits for the consumer.
        bus_if.out_ready = 1'b0;
        expect_blk(a ^ b);
        expect_blk(b);
        expect_blk(c);
        expect_blk(d);
        push(a ^ b);
        push(b);
        push(c);
        check("full_in_ready", c_B'(bus_if.in_ready), c_B'(0));
        n = 0;
        while (!bus_if.out_valid && n < 100) begin
            n++;
            tick();
        end
        repeat (3) tick();
        check("bp_out_valid", c_B'(bus_if.out_valid), c_B'(1));
        check("bp_out_held", bus_if.out_data, stub_fn(a ^ b));
        check("bp_no_launch", c_B'(bus_if.core_en), c_B'(0));
        check("bp_idle", c_B'(busy), c_B'(0));
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = d;
        tick();
        check("bp_launch_b", c_B'(bus_if.core_en), c_B'(1));
        check("bp_launch_b_data", bus_if.core_inp, b);
        check("bp_slot_free", c_B'(bus_if.in_ready), c_B'(1));
        tick();
        bus_if.in_valid = 1'b0;
        check("bp_d_taken", c_B'(bus_if.in_ready), c_B'(0));
        wait_drain();

        // Timeout: core never answers.
        stub_on = 1'b0;
        saved   = blk_count;
        push(f);
        tick();
        check("to_launch", c_B'(bus_if.core_en), c_B'(1));
        repeat (39) tick();
        check("to_not_early", c_B'(err_timeout), c_B'(0));
        check("to_still_run", c_B'(bus_if.core_en), c_B'(1));
        tick();
        check("to_err", c_B'(err_timeout), c_B'(1));
        check("to_core_en", c_B'(bus_if.core_en), c_B'(0));
        check("to_blk_count", c_B'(blk_count), c_B'(saved));
        check("to_out_valid", c_B'(bus_if.out_valid), c_B'(0));
        stub_on = 1'b1;
        expect_blk(g);
        push(g);
        wait_drain();
        check("to_sticky", c_B'(err_timeout), c_B'(1));

        // Clear in the middle of a run, then a stray core_F.
        bus_if.out_ready = 1'b0;
        push(h);
        tick();
        repeat (10) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_blk = 16'd0;
        check_reset_state("midrun_clr");
        manual_data = h;
        manual_f    = 1'b1;
        tick();
        manual_f = 1'b0;
        tick();
        check("stray_f_out_valid", c_B'(bus_if.out_valid), c_B'(0));
        check("stray_f_blk_count", c_B'(blk_count), c_B'(0));
        check("stray_f_busy", c_B'(busy), c_B'(0));

        // Counter wrap.
        force dut.r_blk_count = 16'hFFFF;
        tick();
        release dut.r_blk_count;
        tick();
        check("wrap_preload", c_B'(blk_count), c_B'(16'hFFFF));
        exp_blk = 16'hFFFF;
        bus_if.out_ready = 1'b1;
        expect_blk(c ^ h);
        push(c ^ h);
        wait_drain();
        check("wrap_blk_count", c_B'(blk_count), c_B'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
